// File: rtl/freq_meas_ctrl.sv
// rtl/freq_meas_ctrl.sv - four-channel gated rising-edge frequency counter with sweep sequencing
module freq_meas_ctrl #(
  parameter int GATE_TICKS = 100000000,
  parameter int CW         = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [3:0]    IN,
  input  logic [3:0]    CH_EN,
  input  logic          START,
  input  logic          CONT,
  input  logic          ABORT,
  output logic          BUSY,
  output logic          DONE,
  output logic [1:0]    CH,
  output logic [CW-1:0] FREQ,
  output logic          OVF,
  output logic          VALID
);

  localparam int TW = $clog2(GATE_TICKS + 1);

  typedef enum logic [1:0] {IDLE, SETTLE, GATE, STORE} state_t;

  state_t        state, state_nxt;
  logic [3:0]    sync1, sync2;
  logic [3:0]    mask, mask_nxt;
  logic [1:0]    ch_sel, ch_nxt;
  logic          settle_cnt;
  logic [TW-1:0] tick_cnt;
  logic [CW-1:0] edge_cnt, edge_cnt_nxt;
  logic          ovf_flag, ovf_nxt;
  logic          prev;
  logic          sel_in, rise, gate_last, publish;
  logic [2:0]    lo_en, nx_mask;

  // Returns {hit, index} of the lowest set bit of m at or above index from.
  function automatic logic [2:0] first_from(input logic [3:0] m, input int from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && i >= from) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  assign sel_in    = sync2[ch_sel];
  assign rise      = sel_in & ~prev;
  assign gate_last = (tick_cnt == TW'(GATE_TICKS - 1));
  assign publish   = (state == GATE) && gate_last && !ABORT;
  assign lo_en     = first_from(CH_EN, 0);
  assign nx_mask   = first_from(mask, int'(ch_sel) + 1);

  // Saturating count; the flag records that at least one edge was lost.
  always_comb begin
    edge_cnt_nxt = edge_cnt;
    ovf_nxt      = ovf_flag;
    if (rise) begin
      if (edge_cnt == {CW{1'b1}}) ovf_nxt = 1'b1;
      else                        edge_cnt_nxt = edge_cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    ch_nxt    = ch_sel;
    case (state)
      IDLE: begin
        if (START && CH_EN != 4'b0000) begin
          mask_nxt  = CH_EN;
          ch_nxt    = lo_en[1:0];
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (settle_cnt) state_nxt = GATE;
      end
      GATE: begin
        if (gate_last) state_nxt = STORE;
      end
      STORE: begin
        if (nx_mask[2]) begin
          ch_nxt    = nx_mask[1:0];
          state_nxt = SETTLE;
        end else if (CONT) begin
          mask_nxt  = CH_EN;
          ch_nxt    = lo_en[1:0];
          state_nxt = lo_en[2] ? SETTLE : IDLE;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (ABORT && state != IDLE) begin
      state_nxt = IDLE;
      mask_nxt  = mask;
      ch_nxt    = ch_sel;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      sync1      <= '0;
      sync2      <= '0;
      mask       <= '0;
      ch_sel     <= '0;
      settle_cnt <= 1'b0;
      tick_cnt   <= '0;
      edge_cnt   <= '0;
      ovf_flag   <= 1'b0;
      prev       <= 1'b0;
      FREQ       <= '0;
      CH         <= '0;
      OVF        <= 1'b0;
      VALID      <= 1'b0;
    end else begin
      sync1      <= IN;
      sync2      <= sync1;
      state      <= state_nxt;
      mask       <= mask_nxt;
      ch_sel     <= ch_nxt;
      settle_cnt <= (state == SETTLE) ? ~settle_cnt : 1'b0;
      if (state == SETTLE) begin
        tick_cnt <= '0;
        edge_cnt <= '0;
        ovf_flag <= 1'b0;
        prev     <= sel_in;
      end else if (state == GATE) begin
        tick_cnt <= tick_cnt + TW'(1);
        edge_cnt <= edge_cnt_nxt;
        ovf_flag <= ovf_nxt;
        prev     <= sel_in;
      end
      // Results land as GATE exits so they are visible during the STORE/DONE cycle.
      if (publish) begin
        FREQ  <= edge_cnt_nxt;
        CH    <= ch_sel;
        OVF   <= ovf_nxt;
        VALID <= 1'b1;
      end
    end
  end

  assign BUSY = (state != IDLE);
  assign DONE = (state == STORE);

endmodule

// File: tb/tb_freq_meas_ctrl.sv
// tb/tb_freq_meas_ctrl.sv - scoreboard bench for freq_meas_ctrl
module tb_freq_meas_ctrl;
  localparam int GT = 1000;
  localparam int CW = 8;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [3:0]    IN = 4'b0000;
  logic [3:0]    CH_EN = 4'b0000;
  logic          START = 1'b0;
  logic          CONT = 1'b0;
  logic          ABORT = 1'b0;
  logic          BUSY, DONE, OVF, VALID;
  logic [1:0]    CH;
  logic [CW-1:0] FREQ;

  freq_meas_ctrl #(.GATE_TICKS(GT), .CW(CW)) dut (
    .CLK(CLK), .RST(RST), .IN(IN), .CH_EN(CH_EN), .START(START), .CONT(CONT),
    .ABORT(ABORT), .BUSY(BUSY), .DONE(DONE), .CH(CH), .FREQ(FREQ), .OVF(OVF),
    .VALID(VALID)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {int cyc; int ch; int freq; int ovf;} exp_t;
  exp_t sb[$];

  // period > 0: square wave; 0: held low; -1: held high
  int period[4] = '{0, 0, 0, 0};
  int ph[4]     = '{0, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int c, input int ch, input int f, input int o);
    exp_t e;
    e.cyc = c; e.ch = ch; e.freq = f; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic pulse_start(output int c, input logic exp_busy);
    @(negedge CLK);
    START = 1'b1;
    c = cyc;
    @(negedge CLK);
    START = 1'b0;
    check("busy_after_start", 32'(BUSY), 32'(exp_busy));
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (BUSY !== 1'b0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("idle_reached", 32'(BUSY), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  32'(BUSY),  32'd0);
    check({tag, "_done"},  32'(DONE),  32'd0);
    check({tag, "_ch"},    32'(CH),    32'd0);
    check({tag, "_freq"},  32'(FREQ),  32'd0);
    check({tag, "_ovf"},   32'(OVF),   32'd0);
    check({tag, "_valid"}, 32'(VALID), 32'd0);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      for (int k = 0; k < 4; k++) begin
        if (period[k] > 0) begin
          ph[k] = (ph[k] + 1) % period[k];
          IN[k] = (ph[k] < period[k] / 2);
        end else begin
          IN[k] = (period[k] < 0);
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (DONE === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(DONE), 32'd0);
        end else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.cyc);
          check("done_ch", 32'(CH), e.ch);
          check("done_freq", 32'(FREQ), e.freq);
          check("done_ovf", 32'(OVF), e.ovf);
          check("done_valid", 32'(VALID), 32'd1);
        end
      end
    end
  end

  initial begin
    int c, n;
    repeat (3) @(negedge CLK);
    check_all_zero("reset");
    RST = 1'b0;

    // single channel, latency and BUSY drop
    period[0] = 10;
    CH_EN = 4'b0001;
    pulse_start(c, 1'b1);
    push(c + GT + 3, 0, 100, 0);
    n = 0;
    while (DONE !== 1'b1 && n < GT + 100) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    check("busy_after_done", 32'(BUSY), 32'd0);

    // two-channel sweep, mask change mid-sweep ignored
    period[0] = 0; period[1] = 20; period[3] = 50;
    CH_EN = 4'b1010;
    pulse_start(c, 1'b1);
    push(c + GT + 3, 1, 50, 0);
    push(c + 2 * (GT + 3), 3, 20, 0);
    @(negedge CLK);
    CH_EN = 4'b1111;
    wait_idle(3 * GT);
    check("sb_empty_sweep", sb.size(), 32'd0);

    // saturation at CW=8
    period[0] = 2;
    CH_EN = 4'b0001;
    pulse_start(c, 1'b1);
    push(c + GT + 3, 0, 255, 1);
    wait_idle(2 * GT);

    // level held high across a channel switch is not an edge
    period[0] = 10; period[1] = -1;
    CH_EN = 4'b0011;
    pulse_start(c, 1'b1);
    push(c + GT + 3, 0, 100, 0);
    push(c + 2 * (GT + 3), 1, 0, 0);
    wait_idle(3 * GT);

    // continuous mode, stopped during the third sweep
    period[1] = 0;
    CH_EN = 4'b0001;
    CONT = 1'b1;
    pulse_start(c, 1'b1);
    for (int k = 1; k <= 3; k++) push(c + k * (GT + 3), 0, 100, 0);
    n = 0;
    while (sb.size() > 1 && n < 3 * GT) begin
      @(negedge CLK);
      n++;
    end
    repeat (10) @(negedge CLK);
    CONT = 1'b0;
    wait_idle(2 * GT);
    check("sb_empty_cont", sb.size(), 32'd0);

    // abort mid-gate: no DONE, result registers hold
    pulse_start(c, 1'b1);
    repeat (501) @(negedge CLK);
    ABORT = 1'b1;
    @(negedge CLK);
    ABORT = 1'b0;
    check("abort_busy", 32'(BUSY), 32'd0);
    check("abort_freq", 32'(FREQ), 32'd100);
    check("abort_valid", 32'(VALID), 32'd1);
    repeat (GT + 100) @(negedge CLK);
    CH_EN = 4'b0000;
    pulse_start(c, 1'b0);
    repeat (5) @(negedge CLK);
    check("empty_mask_busy", 32'(BUSY), 32'd0);

    // reset mid-gate clears everything including VALID
    CH_EN = 4'b0001;
    pulse_start(c, 1'b1);
    repeat (501) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check_all_zero("mid_rst");
    repeat (GT + 100) @(negedge CLK);

    // input already high at start is not counted
    period[0] = -1;
    pulse_start(c, 1'b1);
    push(c + GT + 3, 0, 0, 0);
    wait_idle(2 * GT);
    check("sb_empty_end", sb.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
